// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, sequencer states
// and the bus-multiplexer select layout.
package proc_pkg;

    localparam int N_REGS = 8;
    localparam int SEL_W  = 10;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Bus select bit positions; Rn sits at SEL_R0 - n.
    localparam int SEL_DIN = 0;
    localparam int SEL_G   = 1;
    localparam int SEL_R0  = 9;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Control sequencer: decodes IR and drives bus select, load enables and
// ALU control over T0..T3. All outputs are combinational from state, ir, run.
module proc_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int IR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [IR_W-1:0]      ir,
    output logic [SEL_W-1:0]     sel,
    output logic [N_REGS-1:0]    r_in,
    output logic                 a_in,
    output logic                 g_in,
    output logic                 add_sub,
    output logic                 ir_in,
    output logic                 done
);

    // Handshake: run is sampled only in T0; a cycle with ir_in=1 is the fetch.
    // done=1 marks the last cycle of the instruction, and with run still high
    // the following cycle is already the next fetch.
    state_t state, state_next;

    logic [2:0] opcode, rx, ry;
    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];

    logic       wr_en;
    logic       reg_sel_en;
    logic [2:0] reg_sel;
    logic       sel_din;
    logic       sel_g;
    logic [7:0] reg_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= T0;
        else     state <= state_next;
    end

    // rst gates the decode so outputs are quiet during reset, even with run=1.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        reg_sel_en = 1'b0;
        reg_sel    = ry;
        sel_din    = 1'b0;
        sel_g      = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        add_sub    = 1'b0;
        ir_in      = 1'b0;
        done       = 1'b0;
        if (!rst) begin
            case (state)
                T0: begin
                    if (run) begin
                        ir_in      = 1'b1;
                        state_next = T1;
                    end
                end
                T1: begin
                    state_next = T0;
                    case (opcode)
                        OP_MV: begin
                            reg_sel    = ry;
                            reg_sel_en = 1'b1;
                            wr_en      = 1'b1;
                            done       = 1'b1;
                        end
                        OP_MVI: begin
                            sel_din = 1'b1;
                            wr_en   = 1'b1;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            reg_sel    = rx;
                            reg_sel_en = 1'b1;
                            a_in       = 1'b1;
                            state_next = T2;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    reg_sel    = ry;
                    reg_sel_en = 1'b1;
                    g_in       = 1'b1;
                    add_sub    = (opcode == OP_SUB);
                    state_next = T3;
                end
                T3: begin
                    sel_g      = 1'b1;
                    wr_en      = 1'b1;
                    done       = 1'b1;
                    state_next = T0;
                end
                default: state_next = T0;
            endcase
        end
    end

    dec3to8 u_wr_dec (
        .en (wr_en),
        .a  (rx),
        .y  (r_in)
    );

    dec3to8 u_sel_dec (
        .en (reg_sel_en),
        .a  (reg_sel),
        .y  (reg_dec)
    );

    // Register selects are bit-reversed onto sel[9:2]: Rn drives sel[9-n].
    always_comb begin
        sel          = '0;
        sel[SEL_DIN] = sel_din;
        sel[SEL_G]   = sel_g;
        for (int k = 0; k < N_REGS; k++) begin
            sel[SEL_R0-k] = reg_dec[k];
        end
    end

endmodule
